// File: rtl/calc_rs_pkg.sv
// Shared types for the calc reservation station: type codes,
// default widths and the RS entry bundle.
package calc_rs_pkg;

  localparam int TYPE_W_DEF = 6;
  localparam int ROB_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;

  typedef logic [TYPE_W_DEF-1:0] type_t;

  localparam type_t T_NONE  = 6'd0;
  localparam type_t T_LUI   = 6'd1;
  localparam type_t T_AUIPC = 6'd2;
  localparam type_t T_JAL   = 6'd3;
  localparam type_t T_JALR  = 6'd4;
  localparam type_t T_BEQ   = 6'd5;
  localparam type_t T_BNE   = 6'd6;
  localparam type_t T_BLT   = 6'd7;
  localparam type_t T_BGE   = 6'd8;
  localparam type_t T_BLTU  = 6'd9;
  localparam type_t T_BGEU  = 6'd10;
  localparam type_t T_LB    = 6'd11;
  localparam type_t T_LH    = 6'd12;
  localparam type_t T_LW    = 6'd13;
  localparam type_t T_LBU   = 6'd14;
  localparam type_t T_LHU   = 6'd15;
  localparam type_t T_SB    = 6'd16;
  localparam type_t T_SH    = 6'd17;
  localparam type_t T_SW    = 6'd18;
  localparam type_t T_ADDI  = 6'd19;
  localparam type_t T_SLTI  = 6'd20;
  localparam type_t T_SLTIU = 6'd21;
  localparam type_t T_XORI  = 6'd22;
  localparam type_t T_ORI   = 6'd23;
  localparam type_t T_ANDI  = 6'd24;
  localparam type_t T_SLLI  = 6'd25;
  localparam type_t T_SRLI  = 6'd26;
  localparam type_t T_SRAI  = 6'd27;
  localparam type_t T_ADD   = 6'd28;
  localparam type_t T_SUB   = 6'd29;
  localparam type_t T_SLL   = 6'd30;
  localparam type_t T_SLT   = 6'd31;
  localparam type_t T_SLTU  = 6'd32;
  localparam type_t T_XOR   = 6'd33;
  localparam type_t T_SRL   = 6'd34;
  localparam type_t T_SRA   = 6'd35;
  localparam type_t T_OR    = 6'd36;
  localparam type_t T_AND   = 6'd37;

  typedef struct packed {
    logic                  valid;
    type_t                 typ;
    logic [ROB_W_DEF-1:0]  rob;
    logic                  q1_busy;
    logic [ROB_W_DEF-1:0]  q1;
    logic                  q2_busy;
    logic [ROB_W_DEF-1:0]  q2;
    logic [DATA_W_DEF-1:0] v1;
    logic [DATA_W_DEF-1:0] v2;
    logic [31:0]           imm;
    logic [31:0]           pc;
  } entry_t;

endpackage

// File: rtl/calc_rs_calc_class.sv
// Type code to calc-class flag; shared with the dispatcher.
module calc_class
  import calc_rs_pkg::*;
#(
  parameter int TYPE_W = TYPE_W_DEF
) (
  input  logic [TYPE_W-1:0] typ,
  output logic              calc
);

  always_comb begin
    calc = 1'b0;
    unique case (1'b1)
      (typ == T_LUI),
      (typ == T_AUIPC): calc = 1'b1;
      (typ >= T_ADDI && typ <= T_AND): calc = 1'b1;
      default: calc = 1'b0;
    endcase
  end

endmodule

// File: rtl/calc_rs.sv
// Calc-class reservation station between dispatcher and ALU.
// Build option CALC_RS_ISSUE_BYPASS_EN resolves operands from the CDB at issue.
module calc_rs
  import calc_rs_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = ROB_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TYPE_W  = TYPE_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic [TYPE_W-1:0] iss_type,
  input  logic [ROB_W-1:0]  iss_rob,
  input  logic              iss_q1_busy,
  input  logic              iss_q2_busy,
  input  logic [ROB_W-1:0]  iss_q1,
  input  logic [ROB_W-1:0]  iss_q2,
  input  logic [DATA_W-1:0] iss_v1,
  input  logic [DATA_W-1:0] iss_v2,
  input  logic [31:0]       iss_imm,
  input  logic [31:0]       iss_pc,
  output logic              full,
  output logic              reject,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_rob,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              exe_valid,
  output logic [TYPE_W-1:0] exe_type,
  output logic [DATA_W-1:0] exe_v1,
  output logic [DATA_W-1:0] exe_v2,
  output logic [31:0]       exe_imm,
  output logic [31:0]       exe_pc,
  output logic [ROB_W-1:0]  exe_rob
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;

  entry_t        ent   [RS_SIZE];
  entry_t        ent_d [RS_SIZE];
  entry_t        new_ent;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] rdy_idx;
  logic          free_hit;
  logic          rdy_hit;
  logic          is_calc;
  logic          accept;

  calc_class #(.TYPE_W(TYPE_W)) u_class (
    .typ  (iss_type),
    .calc (is_calc)
  );

  assign accept = iss_valid && !full && is_calc;

  // Lowest-index encoders: scanning downward leaves the smallest hit.
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    rdy_hit  = 1'b0;
    rdy_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent[i].valid) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
      if (ent[i].valid && !ent[i].q1_busy && !ent[i].q2_busy) begin
        rdy_hit = 1'b1;
        rdy_idx = IW'(i);
      end
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.typ     = iss_type;
    new_ent.rob     = iss_rob;
    new_ent.q1_busy = iss_q1_busy;
    new_ent.q1      = iss_q1;
    new_ent.q2_busy = iss_q2_busy;
    new_ent.q2      = iss_q2;
    new_ent.v1      = iss_v1;
    new_ent.v2      = iss_v2;
    new_ent.imm     = iss_imm;
    new_ent.pc      = iss_pc;
`ifdef CALC_RS_ISSUE_BYPASS_EN
    if (cdb_valid && iss_q1_busy && iss_q1 == cdb_rob) begin
      new_ent.q1_busy = 1'b0;
      new_ent.v1      = cdb_val;
    end
    if (cdb_valid && iss_q2_busy && iss_q2 == cdb_rob) begin
      new_ent.q2_busy = 1'b0;
      new_ent.v2      = cdb_val;
    end
`endif
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent[i];
      if (cdb_valid && ent[i].valid) begin
        if (ent[i].q1_busy && ent[i].q1 == cdb_rob) begin
          ent_d[i].q1_busy = 1'b0;
          ent_d[i].v1      = cdb_val;
        end
        if (ent[i].q2_busy && ent[i].q2 == cdb_rob) begin
          ent_d[i].q2_busy = 1'b0;
          ent_d[i].v2      = cdb_val;
        end
      end
    end
    if (rdy_hit) ent_d[rdy_idx].valid = 1'b0;
    // The fired slot is valid pre-edge, so it is never the free slot.
    if (accept && free_hit) ent_d[free_idx] = new_ent;
    cnt_d = cnt + CW'(accept) - CW'(rdy_hit);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      cnt       <= '0;
      full      <= 1'b0;
      reject    <= 1'b0;
      exe_valid <= 1'b0;
      exe_type  <= '0;
      exe_v1    <= '0;
      exe_v2    <= '0;
      exe_imm   <= '0;
      exe_pc    <= '0;
      exe_rob   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
        cnt       <= '0;
        full      <= 1'b0;
        reject    <= 1'b0;
        exe_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) ent[i] <= ent_d[i];
        cnt       <= cnt_d;
        full      <= (cnt_d == CW'(RS_SIZE));
        reject    <= iss_valid && !full && !is_calc;
        exe_valid <= rdy_hit;
        if (rdy_hit) begin
          exe_type <= ent[rdy_idx].typ;
          exe_v1   <= ent[rdy_idx].v1;
          exe_v2   <= ent[rdy_idx].v2;
          exe_imm  <= ent[rdy_idx].imm;
          exe_pc   <= ent[rdy_idx].pc;
          exe_rob  <= ent[rdy_idx].rob;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_rs.sv
// Directed bench for calc_rs: vector table plus wakeup, full,
// flush, hold and issue-bypass sequences.
module tb_calc_rs;
  import calc_rs_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        iss_valid, iss_q1_busy, iss_q2_busy;
  logic [5:0]  iss_type;
  logic [3:0]  iss_rob, iss_q1, iss_q2;
  logic [31:0] iss_v1, iss_v2, iss_imm, iss_pc;
  logic        full, reject;
  logic        cdb_valid;
  logic [3:0]  cdb_rob;
  logic [31:0] cdb_val;
  logic        exe_valid;
  logic [5:0]  exe_type;
  logic [31:0] exe_v1, exe_v2, exe_imm, exe_pc;
  logic [3:0]  exe_rob;

  int checks = 0;
  int failures = 0;

  calc_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .iss_valid(iss_valid), .iss_type(iss_type), .iss_rob(iss_rob),
    .iss_q1_busy(iss_q1_busy), .iss_q2_busy(iss_q2_busy),
    .iss_q1(iss_q1), .iss_q2(iss_q2),
    .iss_v1(iss_v1), .iss_v2(iss_v2),
    .iss_imm(iss_imm), .iss_pc(iss_pc),
    .full(full), .reject(reject),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
    .exe_valid(exe_valid), .exe_type(exe_type),
    .exe_v1(exe_v1), .exe_v2(exe_v2),
    .exe_imm(exe_imm), .exe_pc(exe_pc), .exe_rob(exe_rob)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  typ;
    logic [3:0]  rob;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        fire;
    logic        rej;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [5:0] t, input logic [3:0] rob,
                       input logic b1, input logic [3:0] q1,
                       input logic [31:0] v1,
                       input logic b2, input logic [3:0] q2,
                       input logic [31:0] v2);
    iss_valid   = 1'b1;
    iss_type    = t;
    iss_rob     = rob;
    iss_q1_busy = b1;
    iss_q1      = q1;
    iss_v1      = v1;
    iss_q2_busy = b2;
    iss_q2      = q2;
    iss_v2      = v2;
    iss_imm     = 32'h100 + 32'(rob);
    iss_pc      = 32'h8000 + 32'(rob);
  endtask

  task automatic bcast(input logic [3:0] rob, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_rob   = rob;
    cdb_val   = val;
  endtask

  initial begin
    vecs[0] = '{T_ADDI, 4'd3, 32'h11, 32'h22, 32'h5, 32'h1000, 1, 0};
    vecs[1] = '{T_LUI, 4'd6, 32'h0, 32'h0, 32'hABCDE000, 32'h1004, 1, 0};
    vecs[2] = '{T_AUIPC, 4'd7, 32'h0, 32'h0, 32'h2000, 32'h1008, 1, 0};
    vecs[3] = '{T_AND, 4'd9, 32'hF0F0, 32'h0FF0, 32'h0, 32'h100C, 1, 0};
    vecs[4] = '{T_SRAI, 4'd15, 32'h80000000, 32'h0, 32'h3, 32'h1010, 1, 0};
    vecs[5] = '{T_LW, 4'd1, 32'h40, 32'h0, 32'h8, 32'h1014, 0, 1};
    vecs[6] = '{T_SW, 4'd2, 32'h40, 32'h7, 32'h4, 32'h1018, 0, 1};
    vecs[7] = '{T_BEQ, 4'd4, 32'h1, 32'h1, 32'h10, 32'h101C, 0, 1};

    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    iss_valid = 1'b0; iss_type = '0; iss_rob = '0;
    iss_q1_busy = 1'b0; iss_q2_busy = 1'b0; iss_q1 = '0; iss_q2 = '0;
    iss_v1 = '0; iss_v2 = '0; iss_imm = '0; iss_pc = '0;
    cdb_valid = 1'b0; cdb_rob = '0; cdb_val = '0;
    tick(); tick();
    rst_in = 1'b0;
    chk("rst_full", 32'(full), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_exe_valid", 32'(exe_valid), 0);
    chk("rst_exe_rob", 32'(exe_rob), 0);
    chk("rst_exe_v1", 32'(exe_v1), 0);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].typ, vecs[i].rob, 0, 0, vecs[i].v1, 0, 0, vecs[i].v2);
      iss_imm = vecs[i].imm;
      iss_pc  = vecs[i].pc;
      tick();
      iss_valid = 1'b0;
      chk($sformatf("v%0d_reject", i), 32'(reject), 32'(vecs[i].rej));
      chk($sformatf("v%0d_early", i), 32'(exe_valid), 0);
      tick();
      chk($sformatf("v%0d_fire", i), 32'(exe_valid), 32'(vecs[i].fire));
      chk($sformatf("v%0d_rej_clr", i), 32'(reject), 0);
      chk($sformatf("v%0d_full", i), 32'(full), 0);
      if (vecs[i].fire) begin
        chk($sformatf("v%0d_rob", i), 32'(exe_rob), 32'(vecs[i].rob));
        chk($sformatf("v%0d_type", i), 32'(exe_type), 32'(vecs[i].typ));
        chk($sformatf("v%0d_v1", i), exe_v1, vecs[i].v1);
        chk($sformatf("v%0d_v2", i), exe_v2, vecs[i].v2);
        chk($sformatf("v%0d_imm", i), exe_imm, vecs[i].imm);
        chk($sformatf("v%0d_pc", i), exe_pc, vecs[i].pc);
      end
    end
    tick();

    // wakeup: fire exactly one cycle after the wakeup edge
    issue(T_ADD, 4'd5, 1, 4'd2, 32'h0, 0, 0, 32'h77);
    tick();
    iss_valid = 1'b0;
    chk("wk_pre", 32'(exe_valid), 0);
    bcast(4'd2, 32'h1234);
    tick();
    cdb_valid = 1'b0;
    chk("wk_no_same_edge", 32'(exe_valid), 0);
    tick();
    chk("wk_fire", 32'(exe_valid), 1);
    chk("wk_rob", 32'(exe_rob), 5);
    chk("wk_v1", exe_v1, 32'h1234);
    chk("wk_v2", exe_v2, 32'h77);
    tick();

    // fill, overflow drop, then in-order drain
    for (int i = 0; i < 8; i++) begin
      issue(T_ADD, 4'(i), 1, 4'd9, 32'h0, 0, 0, 32'h3);
      tick();
      if (i == 6) chk("fill_not_full", 32'(full), 0);
    end
    chk("fill_full", 32'(full), 1);
    issue(T_ADD, 4'd15, 0, 0, 32'h1, 0, 0, 32'h1);
    tick();
    iss_valid = 1'b0;
    chk("ovf_full", 32'(full), 1);
    chk("ovf_no_fire", 32'(exe_valid), 0);
    bcast(4'd9, 32'hAA);
    tick();
    cdb_valid = 1'b0;
    chk("drain_wake", 32'(exe_valid), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drain%0d_valid", i), 32'(exe_valid), 1);
      chk($sformatf("drain%0d_rob", i), 32'(exe_rob), 32'(i));
      chk($sformatf("drain%0d_v1", i), exe_v1, 32'hAA);
      if (i == 0) chk("drain_full_drop", 32'(full), 0);
    end
    tick();
    chk("drain_dropped9", 32'(exe_valid), 0);

    // flush with four valid entries, one of them ready
    for (int i = 1; i <= 3; i++) begin
      issue(T_OR, 4'(i), 1, 4'd9, 32'h0, 0, 0, 32'h0);
      tick();
    end
    issue(T_ADDI, 4'd4, 0, 0, 32'h1, 0, 0, 32'h2);
    tick();
    iss_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_exe_valid", 32'(exe_valid), 0);
    chk("fl_full", 32'(full), 0);
    bcast(4'd9, 32'h1);
    tick();
    cdb_valid = 1'b0;
    tick();
    chk("fl_gone", 32'(exe_valid), 0);
    issue(T_XOR, 4'd11, 1, 4'd6, 32'h0, 0, 0, 32'h0);
    tick();
    issue(T_XOR, 4'd12, 1, 4'd6, 32'h0, 0, 0, 32'h0);
    tick();
    iss_valid = 1'b0;
    bcast(4'd6, 32'h55);
    tick();
    cdb_valid = 1'b0;
    tick();
    chk("fl_slot0_rob", 32'(exe_rob), 11);
    tick();
    chk("fl_slot1_rob", 32'(exe_rob), 12);
    tick();

    // rdy_in low freezes everything
    issue(T_ADDI, 4'd4, 0, 0, 32'h9, 0, 0, 32'h8);
    tick();
    iss_valid = 1'b0;
    rdy_in = 1'b0;
    tick(); tick();
    chk("hold_no_fire", 32'(exe_valid), 0);
    rdy_in = 1'b1;
    tick();
    chk("hold_fire", 32'(exe_valid), 1);
    chk("hold_rob", 32'(exe_rob), 4);
    tick();

    // issue-time CDB match
    issue(T_SUB, 4'd8, 0, 0, 32'h20, 1, 4'd7, 32'h0);
    bcast(4'd7, 32'h9);
    tick();
    iss_valid = 1'b0;
    cdb_valid = 1'b0;
    tick();
`ifdef CALC_RS_ISSUE_BYPASS_EN
    chk("byp_fire", 32'(exe_valid), 1);
    chk("byp_v2", exe_v2, 32'h9);
    chk("byp_rob", 32'(exe_rob), 8);
`else
    chk("nobyp_pending", 32'(exe_valid), 0);
    tick();
    chk("nobyp_still", 32'(exe_valid), 0);
    bcast(4'd7, 32'h9);
    tick();
    cdb_valid = 1'b0;
    tick();
    chk("nobyp_fire", 32'(exe_valid), 1);
    chk("nobyp_v2", exe_v2, 32'h9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
